muldiv_unit: RTL

- Iterative multiply/divide unit for the RV64 M extension; the next-generation companion to the combinational ALU.
- Parametrised in XLEN; supports RV64 word (W) forms.
- Valid/ready handshake on input and output, so the pipeline stalls on it.
- Sits beside the ALU in the execute stage; the decoder supplies funct3 as the op.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_div_core.sv | 23 ++
 rtl/muldiv_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and helpers for the iterative multiply/divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } md_state_e;

    localparam int MAX_XLEN = 64;

    // Sign-extend a 32-bit word to the widest supported datapath; callers slice to XLEN.
    function automatic logic [MAX_XLEN-1:0] sext32(input logic [31:0] v);
        return {{(MAX_XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// rtl/muldiv_div_core.sv - one restoring-division step on unsigned magnitudes
module muldiv_div_core #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dbit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            qbit_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    // Shift in the next dividend bit, trial-subtract, and restore on borrow.
    always_comb begin
        shifted = {rem_i, dbit_i};
        trial   = shifted - {1'b0, divisor_i};
        qbit_o  = ~trial[XLEN];
        rem_o   = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV64M multiply/divide unit; MULDIV_RADIX4_MUL_EN selects radix-4 multiply
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW       = $clog2(XLEN) + 1;
    localparam int X2       = 2 * XLEN;
    localparam bit HAS_WORD = (XLEN == 64);

    // Extend a 32-bit value to XLEN, signed or unsigned.
    function automatic logic [XLEN-1:0] widen(input logic [31:0] v, input logic s);
        logic [MAX_XLEN-1:0] w;
        w = s ? sext32(v) : {{(MAX_XLEN-32){1'b0}}, v};
        return w[XLEN-1:0];
    endfunction

    // W forms return bit 31 sign-extended; full-width forms pass through.
    function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] v, input logic w);
        return w ? widen(v[31:0], 1'b1) : v;
    endfunction

    md_state_e       state_q, state_d;
    logic [2:0]      op_q;
    logic            word_q;
    logic            a_neg_q, b_neg_q;
    logic [CW-1:0]   cnt_q, last_q;
    logic [X2-1:0]   acc_q, mc_q;
    logic [XLEN-1:0] mp_q;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic [XLEN-1:0] result_q;

    // Request decode, operand conditioning and special-case detection.
    logic            accept;
    logic            word_eff, a_signed, b_signed, is_div;
    logic [2:0]      op_eff;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val;
    logic            a_neg, b_neg, div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic [CW-1:0]   n_last;

    assign accept = (state_q == S_IDLE) && in_valid && !flush;

    // Classify the offered request; W-form high multiplies collapse to MULW.
    always_comb begin
        word_eff = HAS_WORD && word;
        op_eff   = (word_eff && !op[2]) ? MD_MUL : op;
        is_div   = op_eff[2];
        a_signed = (op_eff == MD_MULH) || (op_eff == MD_MULHSU) ||
                   (op_eff == MD_DIV) || (op_eff == MD_REM);
        b_signed = (op_eff == MD_MULH) || (op_eff == MD_DIV) || (op_eff == MD_REM);
        a_ext    = word_eff ? widen(op1[31:0], a_signed) : op1;
        b_ext    = word_eff ? widen(op2[31:0], b_signed) : op2;
        a_neg    = a_signed && a_ext[XLEN-1];
        b_neg    = b_signed && b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        min_val  = word_eff ? widen(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = is_div && (b_ext == '0);
        div_ovf  = is_div && a_signed && (a_ext == min_val) && (b_ext == '1);
        special  = div_zero || div_ovf;

        special_res = '0;
        if (div_zero) begin
            special_res = op_eff[1] ? fin(a_ext, word_eff) : '1;
        end else if (div_ovf) begin
            special_res = op_eff[1] ? '0 : fin(a_ext, word_eff);
        end

        if (is_div) begin
            n_last = word_eff ? CW'(31) : CW'(XLEN - 1);
        end else begin
`ifdef MULDIV_RADIX4_MUL_EN
            n_last = word_eff ? CW'(15) : CW'(XLEN / 2 - 1);
`else
            n_last = word_eff ? CW'(31) : CW'(XLEN - 1);
`endif
        end
    end

    // One multiply and one divide iteration computed from the current state.
    logic [X2-1:0]   acc_nx, mc_nx, prod;
    logic [XLEN-1:0] mp_nx, rem_nx, quo_nx, quo_f, rem_f, final_res;
    logic            qbit;

    muldiv_div_core #(.XLEN(XLEN)) u_div_core (
        .rem_i     (rem_q),
        .dbit_i    (quo_q[XLEN-1]),
        .divisor_i (dvs_q),
        .rem_o     (rem_nx),
        .qbit_o    (qbit)
    );

    // Shift-add multiply step and final sign fix / result selection.
    always_comb begin
`ifdef MULDIV_RADIX4_MUL_EN
        acc_nx = acc_q + (mp_q[0] ? mc_q : '0) + (mp_q[1] ? {mc_q[X2-2:0], 1'b0} : '0);
        mc_nx  = {mc_q[X2-3:0], 2'b00};
        mp_nx  = {2'b00, mp_q[XLEN-1:2]};
`else
        acc_nx = acc_q + (mp_q[0] ? mc_q : '0);
        mc_nx  = {mc_q[X2-2:0], 1'b0};
        mp_nx  = {1'b0, mp_q[XLEN-1:1]};
`endif
        quo_nx = {quo_q[XLEN-2:0], qbit};
        prod   = (a_neg_q ^ b_neg_q) ? -acc_nx : acc_nx;
        quo_f  = (a_neg_q ^ b_neg_q) ? -quo_nx : quo_nx;
        rem_f  = a_neg_q ? -rem_nx : rem_nx;

        final_res = '0;
        case (op_q)
            MD_MUL:                       final_res = fin(prod[XLEN-1:0], word_q);
            MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod[X2-1:XLEN];
            MD_DIV, MD_DIVU:              final_res = fin(quo_f, word_q);
            default:                      final_res = fin(rem_f, word_q);
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == last_q) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    // Datapath: latch operands on accept, iterate in CALC, register the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            word_q   <= 1'b0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            cnt_q    <= '0;
            last_q   <= '0;
            acc_q    <= '0;
            mc_q     <= '0;
            mp_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q    <= op_eff;
            word_q  <= word_eff;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            cnt_q   <= '0;
            last_q  <= n_last;
            acc_q   <= '0;
            mc_q    <= {{XLEN{1'b0}}, a_mag};
            mp_q    <= b_mag;
            rem_q   <= '0;
            // W-form dividend magnitude fits in 32 bits; park it at the top so it shifts out first.
            quo_q   <= word_eff ? (a_mag << 32) : a_mag;
            dvs_q   <= b_mag;
            if (special) begin
                result_q <= special_res;
            end
        end else if (state_q == S_CALC && !flush) begin
            cnt_q <= cnt_q + CW'(1);
            if (op_q[2]) begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
            end else begin
                acc_q <= acc_nx;
                mc_q  <= mc_nx;
                mp_q  <= mp_nx;
            end
            if (cnt_q == last_q) begin
                result_q <= final_res;
            end
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;

endmodule
